// File: rtl/paralelo_serial_param.sv
// rtl/paralelo_serial_param.sv - parallel-to-serial framer with idle fill and a start-up sync phase
module paralelo_serial_param #(
    parameter int                DATA_W    = 8,
    parameter int                LANE_W    = 2,
    parameter logic [DATA_W-1:0] IDLE_SYM  = DATA_W'(8'hBC),
    parameter int                MSB_FIRST = 1,
    parameter int                MIN_IDLE  = 4
) (
    input  logic              clk16f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] paralelo,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] serial,
    output logic              frame_start,
    output logic              data_active
);

    localparam int SLICES = DATA_W / LANE_W;
    localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);

    typedef enum logic {
        ST_SYNC,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic [DATA_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        sync_q, sync_d;
    logic [LANE_W-1:0] serial_q, serial_d;
    logic              frame_start_q, frame_start_d;
    logic              data_active_q, data_active_d;

    logic boundary;
    logic accept;

    function automatic logic [LANE_W-1:0] slice_of(input logic [DATA_W-1:0] w,
                                                   input logic [CNT_W-1:0]  c);
        if (MSB_FIRST != 0)
            return LANE_W'(w >> (DATA_W - LANE_W - LANE_W * int'(c)));
        else
            return LANE_W'(w >> (LANE_W * int'(c)));
    endfunction

    assign boundary = (cnt_q == LAST_SLICE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk16f) begin
        if (!reset_L) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_SYNC && boundary && sync_q == 8'(MIN_IDLE - 1)) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        in_ready = 1'b0;
        if (reset_L && state_q == ST_RUN) begin
            in_ready = !buf_full_q || boundary;
        end
    end

    // The frame register only ever loads from the buffer, so an accepted word
    // always spends at least one edge there before it is serialised.
    always_comb begin
        buf_d         = buf_q;
        buf_full_d    = buf_full_q;
        frame_d       = frame_q;
        cnt_d         = cnt_q + 1'b1;
        sync_d        = sync_q;
        frame_start_d = 1'b0;
        data_active_d = data_active_q;
        if (boundary) begin
            frame_d       = buf_full_q ? buf_q : IDLE_SYM;
            cnt_d         = '0;
            frame_start_d = 1'b1;
            data_active_d = buf_full_q;
            buf_full_d    = 1'b0;
            if (state_q == ST_SYNC) begin
                sync_d = sync_q + 8'd1;
            end
        end
        if (accept) begin
            buf_d      = paralelo;
            buf_full_d = 1'b1;
        end
        serial_d = slice_of(frame_d, cnt_d);
    end

    always_ff @(posedge clk16f) begin
        if (!reset_L) begin
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            frame_q       <= '0;
            cnt_q         <= LAST_SLICE;
            sync_q        <= '0;
            serial_q      <= '0;
            frame_start_q <= 1'b0;
            data_active_q <= 1'b0;
        end else begin
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
            frame_q       <= frame_d;
            cnt_q         <= cnt_d;
            sync_q        <= sync_d;
            serial_q      <= serial_d;
            frame_start_q <= frame_start_d;
            data_active_q <= data_active_d;
        end
    end

    assign serial      = serial_q;
    assign frame_start = frame_start_q;
    assign data_active = data_active_q;

endmodule

// File: tb/tb_paralelo_serial_param.sv
// tb/tb_paralelo_serial_param.sv - scoreboard bench for paralelo_serial_param
module tb_paralelo_serial_param;

    localparam int SLICES = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_L, in_valid, in_ready, frame_start, data_active;
    logic [7:0] paralelo;
    logic [1:0] serial;

    logic       reset2_L, in_valid2, in_ready2, fs2, da2;
    logic [7:0] p2;
    logic [3:0] serial2;

    paralelo_serial_param dut (
        .clk16f      (clk),
        .reset_L     (reset_L),
        .paralelo    (paralelo),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .serial      (serial),
        .frame_start (frame_start),
        .data_active (data_active)
    );

    paralelo_serial_param #(.DATA_W(8), .LANE_W(4), .MSB_FIRST(0)) dut2 (
        .clk16f      (clk),
        .reset_L     (reset2_L),
        .paralelo    (p2),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .serial      (serial2),
        .frame_start (fs2),
        .data_active (da2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0] word;
        int         gap;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: rebuilds each frame from its slices and checks it against the queue.
    logic       rst_seen = 1'b1;
    logic       in_frame = 1'b0;
    logic       expect_start = 1'b0;
    logic       da_frame = 1'b0;
    logic [7:0] asm_w = '0;
    int         idx = 0;
    int         idle_cnt = 0;
    exp_t       e;

    always @(posedge clk) rst_seen = !reset_L;

    always @(negedge clk) begin
        if (rst_seen) begin
            in_frame     = 1'b0;
            expect_start = 1'b0;
            idx          = 0;
            idle_cnt     = 0;
        end else begin
            if (expect_start) begin
                chk("frame_start_pos", 32'(frame_start), 32'd1);
                expect_start = 1'b0;
            end
            if (frame_start) begin
                if (in_frame) begin
                    n_checks++;
                    $display("FAIL frame_len: got %0d slices expected %0d", idx, SLICES);
                end
                in_frame = 1'b1;
                idx      = 1;
                asm_w    = {6'd0, serial};
                da_frame = data_active;
            end else if (in_frame) begin
                idx++;
                asm_w = {asm_w[5:0], serial};
                chk("da_stable", 32'(data_active), 32'(da_frame));
            end
            if (in_frame && idx == SLICES) begin
                if (da_frame) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_data: got %0h expected no data frame", asm_w);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_word", 32'(asm_w), 32'(e.word));
                        chk("idle_gap", 32'(idle_cnt), 32'(e.gap));
                    end
                    idle_cnt = 0;
                end else begin
                    chk("idle_word", 32'(asm_w), 32'hBC);
                    idle_cnt++;
                end
                in_frame     = 1'b0;
                expect_start = 1'b1;
            end
        end
    end

    task automatic send(input logic [7:0] w, output int waited);
        waited   = 0;
        paralelo = w;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                paralelo = w;
                break;
            end
            paralelo = ~w;
            waited++;
        end
        if (waited >= 50) begin
            n_checks++;
            $display("FAIL send_timeout: got no in_ready expected accept of %0h", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        paralelo = 8'hEE;
    endtask

    logic done2 = 1'b0;

    initial begin
        reset2_L  = 1'b0;
        in_valid2 = 1'b0;
        p2        = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset2_L = 1'b1;
        @(posedge clk); #1;
        chk("lsb_idle_s0", 32'(serial2), 32'hC);
        chk("lsb_idle_fs", 32'(fs2), 32'd1);
        @(posedge clk); #1;
        chk("lsb_idle_s1", 32'(serial2), 32'hB);
        chk("lsb_idle_fs1", 32'(fs2), 32'd0);
        repeat (4) @(posedge clk); #1;
        chk("lsb_sync_ready", 32'(in_ready2), 32'd0);
        @(posedge clk); #1;
        chk("lsb_run_ready", 32'(in_ready2), 32'd1);
        in_valid2 = 1'b1;
        p2        = 8'h5A;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        p2        = 8'h00;
        @(posedge clk); #1;
        chk("lsb_data_s0", 32'(serial2), 32'hA);
        chk("lsb_data_fs", 32'(fs2), 32'd1);
        chk("lsb_data_da", 32'(da2), 32'd1);
        @(posedge clk); #1;
        chk("lsb_data_s1", 32'(serial2), 32'h5);
        chk("lsb_data_da1", 32'(da2), 32'd1);
        @(posedge clk); #1;
        chk("lsb_back_idle", 32'(serial2), 32'hC);
        chk("lsb_back_da", 32'(da2), 32'd0);
        done2 = 1'b1;
    end

    int w;

    initial begin
        reset_L  = 1'b0;
        in_valid = 1'b0;
        paralelo = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_serial", 32'(serial), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_da", 32'(data_active), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        reset_L = 1'b1;

        @(posedge clk); #1;
        chk("idle1_slice0", 32'(serial), 32'h2);
        chk("idle1_fs", 32'(frame_start), 32'd1);
        chk("idle1_da", 32'(data_active), 32'd0);
        chk("idle1_ready", 32'(in_ready), 32'd0);
        repeat (11) @(posedge clk); #1;
        chk("sync_ready_e12", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("run_ready_e13", 32'(in_ready), 32'd1);

        exp_q.push_back('{8'hA5, 4});
        send(8'hA5, w);
        chk("a5_wait", 32'(w), 32'd0);
        chk("full_not_ready", 32'(in_ready), 32'd0);
        exp_q.push_back('{8'h3C, 0});
        send(8'h3C, w);
        chk("3c_wait", 32'(w), 32'd2);
        exp_q.push_back('{8'hFF, 0});
        send(8'hFF, w);
        chk("ff_wait", 32'(w), 32'd3);
        exp_q.push_back('{8'h77, 0});
        send(8'h77, w);
        chk("77_wait", 32'(w), 32'd3);

        // 11 starts serialising while 22 sits in the buffer; both are lost to reset.
        send(8'h11, w);
        chk("11_wait", 32'(w), 32'd3);
        send(8'h22, w);
        chk("22_wait", 32'(w), 32'd3);
        @(posedge clk); #1;
        chk("mid_frame_da", 32'(data_active), 32'd1);
        reset_L = 1'b0;
        @(posedge clk); #1;
        chk("midrst_serial", 32'(serial), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_da", 32'(data_active), 32'd0);
        chk("midrst_fs", 32'(frame_start), 32'd0);
        @(posedge clk); #1;
        reset_L = 1'b1;

        exp_q.push_back('{8'h5A, 7});
        repeat (10) @(posedge clk); #1;
        chk("resync_ready", 32'(in_ready), 32'd0);
        repeat (14) @(posedge clk); #1;
        send(8'h5A, w);
        chk("5a_wait", 32'(w), 32'd0);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (12) @(posedge clk); #1;
        chk("trailing_idle", 32'(idle_cnt >= 2), 32'd1);

        for (int i = 0; i < 1000 && !done2; i++) @(posedge clk);
        chk("lsb_done", 32'(done2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
